// File: rtl/apu_cluster_package.sv
// rtl/apu_cluster_package.sv - shared FP cluster widths and the default result record
package apu_cluster_package;

    localparam int unsigned FP_WIDTH      = 32;
    localparam int unsigned NUSFLAGS_MULT = 5;
    localparam int unsigned TAG_WIDTH_DEF = 4;

    // Fixed-width record; modules with a different TAG_WIDTH declare their own.
    typedef struct packed {
        logic [FP_WIDTH-1:0]      res;
        logic [TAG_WIDTH_DEF-1:0] tag;
        logic [NUSFLAGS_MULT-1:0] status;
    } fp_result_t;

endpackage

// File: rtl/fp_resq_credit_ctr.sv
// rtl/fp_resq_credit_ctr.sv - in-flight credit counter, issue gating and unsolicited-result detect
module fp_resq_credit_ctr #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          issue_en,
    input  logic          unit_valid,
    input  logic [CW-1:0] count,
    output logic          issue_ready,
    output logic          issue_accept,
    output logic [CW-1:0] inflight,
    output logic          unsolicited
);

    // One extra bit so count + inflight cannot wrap before the compare.
    assign issue_ready  = ({1'b0, count} + {1'b0, inflight}) < (CW + 1)'(DEPTH);
    assign issue_accept = issue_en & issue_ready;
    assign unsolicited  = unit_valid & (inflight == '0);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            inflight <= '0;
        end else begin
            case ({issue_accept, unit_valid & ~unsolicited})
                2'b10:   inflight <= inflight + 1'b1;
                2'b01:   inflight <= inflight - 1'b1;
                default: inflight <= inflight;
            endcase
        end
    end

endmodule

// File: rtl/fp_result_queue.sv
// rtl/fp_result_queue.sv - credit-throttled result FIFO behind a non-stallable FP unit (option: FP_RESQ_BYPASS_EN)
module fp_result_queue
    import apu_cluster_package::*;
#(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned TAG_WIDTH  = 4,
    parameter int unsigned STAT_WIDTH = NUSFLAGS_MULT
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  IssueEn_i,
    output logic                  IssueReady_o,
    output logic                  UnitEn_o,
    input  logic                  UnitValid_i,
    input  logic [FP_WIDTH-1:0]   UnitRes_i,
    input  logic [TAG_WIDTH-1:0]  UnitTag_i,
    input  logic [STAT_WIDTH-1:0] UnitStatus_i,
    output logic                  Valid_o,
    output logic [FP_WIDTH-1:0]   Res_o,
    output logic [TAG_WIDTH-1:0]  Tag_o,
    output logic [STAT_WIDTH-1:0] Status_o,
    input  logic                  Ack_i,
    output logic                  Err_o
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned PW = $clog2(DEPTH);

    typedef struct packed {
        logic [FP_WIDTH-1:0]   res;
        logic [TAG_WIDTH-1:0]  tag;
        logic [STAT_WIDTH-1:0] status;
    } entry_t;

    entry_t        mem [DEPTH];
    logic [PW-1:0] wptr, rptr;
    logic [CW-1:0] count;
    logic [CW-1:0] inflight;
    logic          err;

    logic issue_accept, unsolicited;
    logic push_ok, pop_store, overflow, bypass_taken, do_write;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    fp_resq_credit_ctr #(
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_credit (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .issue_en     (IssueEn_i),
        .unit_valid   (UnitValid_i),
        .count        (count),
        .issue_ready  (IssueReady_o),
        .issue_accept (issue_accept),
        .inflight     (inflight),
        .unsolicited  (unsolicited)
    );

    assign UnitEn_o  = issue_accept;
    assign push_ok   = UnitValid_i & ~unsolicited;
    assign pop_store = (count != '0) & Ack_i;
    assign overflow  = push_ok & (count == CW'(DEPTH)) & ~pop_store;

`ifdef FP_RESQ_BYPASS_EN
    // A result consumed straight off the unit never touches storage.
    assign bypass_taken = push_ok & (count == '0) & Ack_i;
`else
    assign bypass_taken = 1'b0;
`endif

    assign do_write = push_ok & ~overflow & ~bypass_taken;

    always_ff @(posedge clk_i) begin
        if (do_write) begin
            mem[wptr] <= '{res: UnitRes_i, tag: UnitTag_i, status: UnitStatus_i};
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            err   <= 1'b0;
        end else begin
            if (do_write)  wptr <= ptr_inc(wptr);
            if (pop_store) rptr <= ptr_inc(rptr);
            case ({do_write, pop_store})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            err <= err | unsolicited | overflow;
        end
    end

    assign Err_o = err;

    always_comb begin
        Valid_o  = 1'b0;
        Res_o    = '0;
        Tag_o    = '0;
        Status_o = '0;
        if (count != '0) begin
            Valid_o  = 1'b1;
            Res_o    = mem[rptr].res;
            Tag_o    = mem[rptr].tag;
            Status_o = mem[rptr].status;
        end
`ifdef FP_RESQ_BYPASS_EN
        else if (push_ok) begin
            Valid_o  = 1'b1;
            Res_o    = UnitRes_i;
            Tag_o    = UnitTag_i;
            Status_o = UnitStatus_i;
        end
`endif
    end

endmodule

// File: tb/tb_fp_result_queue.sv
// tb/tb_fp_result_queue.sv - directed self-checking bench for fp_result_queue (DEPTH=4)
module tb_fp_result_queue;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        IssueEn_i;
    logic        IssueReady_o;
    logic        UnitEn_o;
    logic        UnitValid_i;
    logic [31:0] UnitRes_i;
    logic [3:0]  UnitTag_i;
    logic [4:0]  UnitStatus_i;
    logic        Valid_o;
    logic [31:0] Res_o;
    logic [3:0]  Tag_o;
    logic [4:0]  Status_o;
    logic        Ack_i;
    logic        Err_o;

    int n_total = 0;
    int n_pass  = 0;

    fp_result_queue #(
        .DEPTH      (4),
        .TAG_WIDTH  (4),
        .STAT_WIDTH (5)
    ) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .IssueEn_i    (IssueEn_i),
        .IssueReady_o (IssueReady_o),
        .UnitEn_o     (UnitEn_o),
        .UnitValid_i  (UnitValid_i),
        .UnitRes_i    (UnitRes_i),
        .UnitTag_i    (UnitTag_i),
        .UnitStatus_i (UnitStatus_i),
        .Valid_o      (Valid_o),
        .Res_o        (Res_o),
        .Tag_o        (Tag_o),
        .Status_o     (Status_o),
        .Ack_i        (Ack_i),
        .Err_o        (Err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        IssueEn_i    = 1'b0;
        UnitValid_i  = 1'b0;
        UnitRes_i    = '0;
        UnitTag_i    = '0;
        UnitStatus_i = '0;
        Ack_i        = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_ni = 1'b0;
        step();
        step();
        rst_ni = 1'b1;
        step();
    endtask

    task automatic push_result(input logic [3:0] tag);
        UnitValid_i  = 1'b1;
        UnitTag_i    = tag;
        UnitRes_i    = 32'h100 + 32'(tag);
        UnitStatus_i = 5'(tag);
        step();
        UnitValid_i  = 1'b0;
    endtask

    initial begin
        int accepted;
        int rp, wp;
        int issued, returned, popped, cyc;
        logic pend;
        logic acc;

        idle_inputs();
        rst_ni = 1'b0;
        #2;
        check("reset_valid", 32'(Valid_o), 0);
        check("reset_ready", 32'(IssueReady_o), 1);
        check("reset_err", 32'(Err_o), 0);
        check("reset_res", Res_o, 0);
        step();
        rst_ni = 1'b1;
        step();

        // Basic single op
        IssueEn_i = 1'b1;
        #1;
        check("basic_unit_en", 32'(UnitEn_o), 1);
        step();
        IssueEn_i    = 1'b0;
        UnitValid_i  = 1'b1;
        UnitRes_i    = 32'h3F80_0000;
        UnitTag_i    = 4'd5;
        UnitStatus_i = 5'h01;
        Ack_i        = 1'b1;
        #1;
`ifdef FP_RESQ_BYPASS_EN
        check("basic_bypass_valid", 32'(Valid_o), 1);
        check("basic_bypass_res", Res_o, 32'h3F80_0000);
        step();
        UnitValid_i = 1'b0;
`else
        check("basic_no_bypass", 32'(Valid_o), 0);
        step();
        UnitValid_i = 1'b0;
        check("basic_valid", 32'(Valid_o), 1);
        check("basic_res", Res_o, 32'h3F80_0000);
        check("basic_tag", 32'(Tag_o), 5);
        check("basic_status", 32'(Status_o), 1);
        step();
`endif
        Ack_i = 1'b0;
        check("basic_drained", 32'(Valid_o), 0);
        check("basic_count", 32'(dut.count), 0);

        // Credit throttling
        accepted  = 0;
        IssueEn_i = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (i >= 4) check($sformatf("throttle_ready_c%0d", i), 32'(IssueReady_o), 0);
            if (IssueReady_o) accepted++;
            step();
        end
        IssueEn_i = 1'b0;
        check("throttle_accepted", 32'(accepted), 4);
        for (int t = 0; t < 4; t++) push_result(4'(t));
        check("throttle_count", 32'(dut.count), 4);
        check("throttle_full_ready", 32'(IssueReady_o), 0);
        check("throttle_head_tag", 32'(Tag_o), 0);
        check("throttle_head_res", Res_o, 32'h100);
        Ack_i = 1'b1;
        #1;
        check("ready_not_comb_from_ack", 32'(IssueReady_o), 0);
        step();
        Ack_i = 1'b0;
        check("throttle_ready_after_pop", 32'(IssueReady_o), 1);
        check("throttle_next_tag", 32'(Tag_o), 1);

        // Simultaneous issue + result + pop at Count=2, InFlight=1
        Ack_i = 1'b1;
        step();
        Ack_i     = 1'b0;
        IssueEn_i = 1'b1;
        step();
        check("simul_pre_count", 32'(dut.count), 2);
        check("simul_pre_inflight", 32'(dut.inflight), 1);
        rp = int'(dut.rptr);
        wp = int'(dut.wptr);
        check("simul_pre_head", 32'(Tag_o), 2);
        UnitValid_i = 1'b1;
        UnitTag_i   = 4'd4;
        UnitRes_i   = 32'h104;
        Ack_i       = 1'b1;
        #1;
        check("simul_issue_accepted", 32'(UnitEn_o), 1);
        step();
        IssueEn_i = 1'b0;
        check("simul_count", 32'(dut.count), 2);
        check("simul_inflight", 32'(dut.inflight), 1);
        check("simul_rptr", 32'(dut.rptr), 32'((rp + 1) % 4));
        check("simul_wptr", 32'(dut.wptr), 32'((wp + 1) % 4));
        check("simul_head", 32'(Tag_o), 3);
        UnitTag_i = 4'd5;
        UnitRes_i = 32'h105;
        step();
        UnitValid_i = 1'b0;
        check("order_tag4", 32'(Tag_o), 4);
        check("order_res4", Res_o, 32'h104);
        step();
        check("order_tag5", 32'(Tag_o), 5);
        step();
        Ack_i = 1'b0;
        check("order_empty", 32'(Valid_o), 0);
        check("order_err", 32'(Err_o), 0);

        // Wrap-around stream, unit latency of one cycle, random acks
        issued = 0; returned = 0; popped = 0; pend = 1'b0;
        for (cyc = 0; cyc < 300 && popped < 10; cyc++) begin
            IssueEn_i   = (issued < 10);
            UnitValid_i = pend;
            UnitTag_i   = 4'(returned);
            UnitRes_i   = 32'h200 + 32'(returned);
            Ack_i       = 1'($urandom_range(0, 1));
            #1;
            acc = IssueEn_i & IssueReady_o;
            if (Valid_o && Ack_i) begin
                check($sformatf("wrap_tag%0d", popped), 32'(Tag_o), 32'(popped));
                popped++;
            end
            if (pend) returned++;
            if (acc) issued++;
            step();
            pend = acc;
        end
        idle_inputs();
        check("wrap_popped", 32'(popped), 10);
        check("wrap_err", 32'(Err_o), 0);

        // Unsolicited result
        step();
        check("err_pre_inflight", 32'(dut.inflight), 0);
        UnitValid_i = 1'b1;
        UnitTag_i   = 4'd9;
        step();
        UnitValid_i = 1'b0;
        check("err_set", 32'(Err_o), 1);
        check("err_count", 32'(dut.count), 0);
        check("err_discarded", 32'(Valid_o), 0);
        step();
        step();
        check("err_sticky", 32'(Err_o), 1);

        // Reset mid-operation
        do_reset();
        check("rst_err_cleared", 32'(Err_o), 0);
        IssueEn_i = 1'b1;
        for (int i = 0; i < 4; i++) step();
        IssueEn_i = 1'b0;
        for (int t = 0; t < 3; t++) push_result(4'(t));
        check("rst_pre_count", 32'(dut.count), 3);
        check("rst_pre_inflight", 32'(dut.inflight), 1);
        #2;
        rst_ni = 1'b0;
        #1;
        check("rst_async_valid", 32'(Valid_o), 0);
        check("rst_async_ready", 32'(IssueReady_o), 1);
        step();
        rst_ni = 1'b1;
        step();
        check("rst_after_count", 32'(dut.count), 0);
        check("rst_after_inflight", 32'(dut.inflight), 0);
        check("rst_after_valid", 32'(Valid_o), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
